ecdsa_operand_fetch: RTL
========================

Name: ecdsa_operand_fetch

Overview:
Upstream stage of the Montgomery/ECDSA compute core inside the ECDSA project wrapper. After the CSR block pulses start with ADDR_TABLE_BASE_I and ARGC_I, this block reads the 1024-bit address-table word from the shared BRAM port. It then fetches each referenced 1024-bit operand and streams the operands in order to the core over a valid/ready interface. It owns the BRAM read port only while busy; the AXI-lite CSR block and the core are outside it.

Parameters:
DATA_W, 1024, BRAM word and operand width
ADDR_W, 17, BRAM byte-address width
ENTRY_W, 32, address-table entry width; address = low ADDR_W bits of the entry
MAX_ARGS, 8, maximum argc accepted (must be <= DATA_W/ENTRY_W)
MEM_LAT, 1, BRAM read latency in cycles (1 or 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; sampled only in IDLE
table_base  in  ADDR_W  byte address of the address-table word
argc  in  32  number of operands to fetch
busy  out  1  high from accepted start until done/error
done  out  1  one-cycle pulse after the last operand handshake
error  out  1  one-cycle pulse on rejected argc (or misaligned address with the optional feature)
mem_en  out  1  BRAM read enable
mem_addr  out  ADDR_W  BRAM byte address
mem_dout  in  DATA_W  BRAM read data, valid MEM_LAT cycles after mem_en
op_valid  out  1  operand beat valid
op_ready  in  1  core accepts beat
op_data  out  DATA_W  operand value
op_idx  out  4  operand index, 0-based
op_last  out  1  high on beat idx == argc-1

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, error, mem_en, op_valid, op_last = 0; mem_addr, op_data, op_idx = 0.
- Table layout: entry i occupies bits [DATA_W-1-ENTRY_W*i -: ENTRY_W], so entry 0 is the MSB entry.
- IDLE: on start, latch table_base and argc. If argc==0 or argc>MAX_ARGS, pulse error the next cycle and stay in IDLE with busy low. Otherwise set busy=1 and go to TBL_RD.
- TBL_RD: drive mem_en=1 and mem_addr=table_base for exactly one cycle, then go to TBL_WAIT.
- TBL_WAIT: count MEM_LAT cycles, capture mem_dout into the table register, set idx=0, go to ARG_RD.
- ARG_RD: issue mem_en with the address from entry idx for one cycle, then go to ARG_WAIT.
- ARG_WAIT: after MEM_LAT cycles, capture op_data, set op_valid=1 and op_last=(idx==argc-1), go to OUT.
- OUT: hold op_valid, op_data, op_idx and op_last stable until op_ready. On the handshake, drop op_valid. If last, go to DONE; otherwise increment idx and go to ARG_RD. No prefetch.
- DONE: pulse done for one cycle, clear busy, return to IDLE.
- Latency with MEM_LAT=1 and op_ready tied high: first op_valid appears 5 cycles after start; each following beat needs 3 cycles.
- start while busy is ignored. op_ready while op_valid=0 is ignored. mem_en is never high outside TBL_RD/ARG_RD.
- Reset mid-operation aborts immediately; the core sees no partial beat because op_valid drops asynchronously.

Optional Feature:
ECDSA_FETCH_ALIGN_CHECK_EN
- Defined: table_base and every operand address must be DATA_W/8-byte aligned (low 7 bits zero). A misaligned address detected before its mem_en is issued causes no read; the block pulses error, clears busy and returns to IDLE, and done does not pulse.
- Undefined: addresses are used unchanged with no check.

Decomposition:
- Shared package ecdsa_pkg: state enum, DATA_W/ADDR_W/ENTRY_W constants, and an entry-extract function.
- One natural sub-module, ecdsa_mem_lat_counter: a MEM_LAT wait counter reused by TBL_WAIT and ARG_WAIT.

Test Plan:
- BRAM word at 0x80 = 2<<643, at 0x100 = 3<<643, at 0x180 = 5<<643. Table at 0x200 holds {0x080,0x100,0x180} << (1024-96); argc=3, op_ready=1 -> beats 2<<643, 3<<643, 5<<643 with idx 0/1/2, op_last only on idx 2, then one done pulse.
- Same setup with op_ready low for 10 cycles on each beat -> op_data/op_idx held stable, no extra mem_en, same beat order.
- argc=0 and argc=9 -> error pulse one cycle after start, busy stays 0, no mem_en.
- start pulsed again during the beat for idx 1 -> ignored; exactly 3 beats and 1 done.
- rst asserted in ARG_WAIT -> all outputs 0 in the same cycle; a fresh start afterwards completes normally.
- With ECDSA_FETCH_ALIGN_CHECK_EN, table entry 1 = 0x104 -> beat 0 delivered, then error, no mem_en to 0x104, no done.

Source files
------------

// File: rtl/ecdsa_pkg.sv
// Shared types and constants for the ECDSA operand-fetch stage.
// Optional build macro used by this slice: ECDSA_FETCH_ALIGN_CHECK_EN.
package ecdsa_pkg;

    localparam int unsigned DATA_W   = 1024;
    localparam int unsigned ADDR_W   = 17;
    localparam int unsigned ENTRY_W  = 32;
    localparam int unsigned MAX_ARGS = 8;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned ALIGN_W  = 7;
    localparam int unsigned CNT_W    = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TBL_RD,
        S_TBL_WAIT,
        S_ARG_RD,
        S_ARG_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    // Entry 0 sits in the most significant ENTRY_W bits of the table word.
    function automatic logic [ADDR_W-1:0] entry_addr(input logic [DATA_W-1:0] tbl,
                                                     input logic [IDX_W-1:0]  idx);
        return ADDR_W'(tbl >> (DATA_W - ENTRY_W * (32'(idx) + 32'd1)));
    endfunction

    function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
        return addr[ALIGN_W-1:0] == '0;
    endfunction

endpackage

// File: rtl/ecdsa_operand_fetch_if.sv
// Control, BRAM read port and operand stream of the operand-fetch stage.
interface ecdsa_operand_fetch_if;
    import ecdsa_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] table_base;
    logic [31:0]       argc;
    logic              busy;
    logic              done;
    logic              error;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_data;
    logic [IDX_W-1:0]  op_idx;
    logic              op_last;

    modport master (
        input  start, table_base, argc, mem_dout, op_ready,
        output busy, done, error, mem_en, mem_addr, op_valid, op_data, op_idx, op_last
    );

    modport slave (
        output start, table_base, argc, mem_dout, op_ready,
        input  busy, done, error, mem_en, mem_addr, op_valid, op_data, op_idx, op_last
    );

endinterface

// File: rtl/ecdsa_mem_lat_counter.sv
// Counts BRAM read latency; expired_c marks the cycle read data is valid.
module ecdsa_mem_lat_counter
    import ecdsa_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic expired_c
);

    logic [CNT_W-1:0] cnt;

    assign expired_c = en && (cnt == CNT_W'(LAT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (!expired_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ecdsa_operand_fetch.sv
// Reads the address table, then fetches and streams each operand in order.
// Build macro ECDSA_FETCH_ALIGN_CHECK_EN rejects addresses not on a BRAM word.
module ecdsa_operand_fetch
    import ecdsa_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ecdsa_operand_fetch_if.master bus
);

`ifdef ECDSA_FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    state_t            state;
    state_t            next_state;
    logic              lat_done_c;
    logic              wait_en;
    logic              hs_c;
    logic              last_c;
    logic              argc_bad_c;
    logic              fault_c;
    logic [ADDR_W-1:0] next_addr_c;

    logic [IDX_W-1:0]  argc_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] tbl_q;

    logic              busy_q, done_q, error_q, mem_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              op_valid_q, op_last_q;
    logic [DATA_W-1:0] op_data_q;
    logic [IDX_W-1:0]  op_idx_q;

    logic              busy_d, done_d, error_d, mem_en_d;
    logic [ADDR_W-1:0] mem_addr_d;

    assign wait_en    = (state == S_TBL_WAIT) || (state == S_ARG_WAIT);
    assign hs_c       = op_valid_q && bus.op_ready;
    assign last_c     = (idx_q == argc_q - IDX_W'(1));
    assign argc_bad_c = (bus.argc == 32'd0) || (bus.argc > 32'(MAX_ARGS));

    ecdsa_mem_lat_counter #(.LAT(MEM_LAT)) u_lat (
        .clk       (clk),
        .rst       (rst),
        .en        (wait_en),
        .expired_c (lat_done_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next state plus the address of the read about to be issued (checked before mem_en).
    always_comb begin
        next_state  = state;
        next_addr_c = mem_addr_q;
        fault_c     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (argc_bad_c || (ALIGN_CHK && !is_aligned(bus.table_base))) begin
                        fault_c = 1'b1;
                    end else begin
                        next_state  = S_TBL_RD;
                        next_addr_c = bus.table_base;
                    end
                end
            end
            S_TBL_RD: next_state = S_TBL_WAIT;
            S_TBL_WAIT: begin
                if (lat_done_c) begin
                    next_addr_c = entry_addr(bus.mem_dout, '0);
                    if (ALIGN_CHK && !is_aligned(next_addr_c)) begin
                        fault_c    = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        next_state = S_ARG_RD;
                    end
                end
            end
            S_ARG_RD: next_state = S_ARG_WAIT;
            S_ARG_WAIT: begin
                if (lat_done_c) next_state = S_OUT;
            end
            S_OUT: begin
                if (hs_c) begin
                    if (last_c) begin
                        next_state = S_DONE;
                    end else begin
                        next_addr_c = entry_addr(tbl_q, idx_q + IDX_W'(1));
                        if (ALIGN_CHK && !is_aligned(next_addr_c)) begin
                            fault_c    = 1'b1;
                            next_state = S_IDLE;
                        end else begin
                            next_state = S_ARG_RD;
                        end
                    end
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Control outputs decoded from the upcoming state, registered below.
    always_comb begin
        busy_d     = (next_state != S_IDLE) && (next_state != S_DONE);
        done_d     = (next_state == S_DONE);
        error_d    = fault_c;
        mem_en_d   = (next_state == S_TBL_RD) || (next_state == S_ARG_RD);
        mem_addr_d = mem_en_d ? next_addr_c : mem_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Table/operand capture and the operand beat register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            argc_q     <= '0;
            idx_q      <= '0;
            tbl_q      <= '0;
            op_valid_q <= 1'b0;
            op_last_q  <= 1'b0;
            op_data_q  <= '0;
            op_idx_q   <= '0;
        end else begin
            if (state == S_IDLE && bus.start) argc_q <= IDX_W'(bus.argc);
            if (state == S_TBL_WAIT && lat_done_c) begin
                tbl_q <= bus.mem_dout;
                idx_q <= '0;
            end
            if (state == S_ARG_WAIT && lat_done_c) begin
                op_data_q  <= bus.mem_dout;
                op_idx_q   <= idx_q;
                op_last_q  <= last_c;
                op_valid_q <= 1'b1;
            end
            if (state == S_OUT && hs_c) begin
                op_valid_q <= 1'b0;
                op_last_q  <= 1'b0;
                if (!last_c) idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.mem_en   = mem_en_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.op_valid = op_valid_q;
    assign bus.op_data  = op_data_q;
    assign bus.op_idx   = op_idx_q;
    assign bus.op_last  = op_last_q;

endmodule
